// File: rtl/regfile_arb_pkg.sv
// Shared widths, request record and helpers for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wr_slot.sv
// Single-entry holding slot for one write requester: full flag, request and age bit.
module wr_slot
    import regfile_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    load_i,
    input  logic    grant_i,
    input  logic    load_young_i,
    input  logic    other_grant_i,
    input  wr_req_t req_i,
    output logic    full_o,
    output logic    young_o,
    output wr_req_t req_o
);

    logic    full_q, full_d;
    logic    young_q, young_d;
    wr_req_t req_q, req_d;

    // young means the other slot holds an older request that must drain first
    always_comb begin
        full_d  = full_q;
        young_d = young_q;
        req_d   = req_q;
        if (load_i) begin
            full_d  = 1'b1;
            young_d = load_young_i;
            req_d   = req_i;
        end else begin
            if (grant_i)
                full_d = 1'b0;
            if (grant_i || other_grant_i)
                young_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            young_q <= 1'b0;
            req_q   <= '0;
        end else begin
            full_q  <= full_d;
            young_q <= young_d;
            req_q   <= req_d;
        end
    end

    assign full_o  = full_q;
    assign young_o = young_q;
    assign req_o   = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with registered write port.
// Define ARB_ROUND_ROBIN_EN to alternate different-register contention; otherwise A always wins.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [NUM_REGS-1:0]   pending_mask
);

    logic    a_full, b_full, a_young, b_young;
    wr_req_t a_held, b_held, gnt_req;
    logic    grant_a, grant_b, a_load, b_load;
    logic    a_load_young, b_load_young;
    logic    same_reg, contended;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
`endif

    wr_slot u_slot_a (
        .clk_i        (clock),
        .rst_i        (ctrl_reset),
        .load_i       (a_load),
        .grant_i      (grant_a),
        .load_young_i (a_load_young),
        .other_grant_i(grant_b),
        .req_i        ('{reg_addr: a_reg, data: a_data}),
        .full_o       (a_full),
        .young_o      (a_young),
        .req_o        (a_held)
    );

    wr_slot u_slot_b (
        .clk_i        (clock),
        .rst_i        (ctrl_reset),
        .load_i       (b_load),
        .grant_i      (grant_b),
        .load_young_i (b_load_young),
        .other_grant_i(grant_a),
        .req_i        ('{reg_addr: b_reg, data: b_data}),
        .full_o       (b_full),
        .young_o      (b_young),
        .req_o        (b_held)
    );

    // Same nonzero register must drain oldest-first to keep the final value correct
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        same_reg  = a_full && b_full && (a_held.reg_addr == b_held.reg_addr)
                    && (a_held.reg_addr != '0);
        contended = a_full && b_full && !same_reg;
        if (same_reg) begin
            grant_a = b_young || !a_young;
            grant_b = !grant_a;
        end else if (contended) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_a = !ptr_q;
            grant_b = ptr_q;
`else
            grant_a = 1'b1;
`endif
        end else if (a_full) begin
            grant_a = 1'b1;
        end else if (b_full) begin
            grant_b = 1'b1;
        end
    end

    assign a_ready = !ctrl_reset && (!a_full || grant_a);
    assign b_ready = !ctrl_reset && (!b_full || grant_b);
    assign a_load  = a_valid && a_ready;
    assign b_load  = b_valid && b_ready;

    // A loaded on the same edge as B counts as younger, so B commits first
    assign a_load_young = b_load || (b_full && !grant_b);
    assign b_load_young = a_full && !grant_a;

    always_comb begin
        gnt_req = grant_b ? b_held : a_held;
        we_d    = (grant_a || grant_b) && (gnt_req.reg_addr != '0);
        wreg_d  = we_d ? gnt_req.reg_addr : wreg_q;
        wdata_d = we_d ? gnt_req.data : wdata_q;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign ptr_d = contended ? !ptr_q : ptr_q;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            ptr_q <= 1'b0;
        else
            ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        pending_mask = '0;
        if (a_full)
            pending_mask = pending_mask | reg_onehot(a_held.reg_addr);
        if (b_full)
            pending_mask = pending_mask | reg_onehot(b_held.reg_addr);
        if (we_q)
            pending_mask = pending_mask | reg_onehot(wreg_q);
        pending_mask[0] = 1'b0;
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; build with ARB_ROUND_ROBIN_EN to cover the round-robin variant.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        we;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[5];

    regfile_write_arbiter dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_reg           (a_reg),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_reg           (b_reg),
        .b_data          (b_data),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .pending_mask    (pending_mask)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bd);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkWrite(input string name, input logic [4:0] r, input logic [31:0] d,
                              input logic [31:0] mask);
        checkOutput({name, ".we"}, ctrl_writeEnable, 1'b1);
        checkOutput({name, ".reg"}, ctrl_writeReg, r);
        checkOutput({name, ".data"}, data_writeReg, d);
        checkOutput({name, ".mask"}, pending_mask, mask);
    endtask

    // Contended A r3 / B r7 burst; bFirst selects which requester wins
    task automatic runBurst(input string name, input logic bFirst);
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput({name, ".mask_held"}, pending_mask, 32'h88);
        checkOutput({name, ".a_ready"}, a_ready, !bFirst);
        checkOutput({name, ".b_ready"}, b_ready, bFirst);
        tick();
        if (bFirst) checkWrite({name, ".first"}, 5'd7, 32'h22, 32'h88);
        else        checkWrite({name, ".first"}, 5'd3, 32'h11, 32'h88);
        tick();
        if (bFirst) checkWrite({name, ".second"}, 5'd3, 32'h11, 32'h08);
        else        checkWrite({name, ".second"}, 5'd7, 32'h22, 32'h80);
        tick();
        checkOutput({name, ".idle_we"}, ctrl_writeEnable, 1'b0);
        checkOutput({name, ".idle_mask"}, pending_mask, 32'h0);
    endtask

    initial begin
        logic rrSecondB;
        vecs[0] = '{r: 5'd5,  d: 32'h0000_00AA, we: 1'b1, mask: 32'h0000_0020};
        vecs[1] = '{r: 5'd31, d: 32'hDEAD_BEEF, we: 1'b1, mask: 32'h8000_0000};
        vecs[2] = '{r: 5'd1,  d: 32'h0000_0001, we: 1'b1, mask: 32'h0000_0002};
        vecs[3] = '{r: 5'd0,  d: 32'h0000_0055, we: 1'b0, mask: 32'h0000_0000};
        vecs[4] = '{r: 5'd16, d: 32'h1234_5678, we: 1'b1, mask: 32'h0001_0000};
`ifdef ARB_ROUND_ROBIN_EN
        rrSecondB = 1'b1;
`else
        rrSecondB = 1'b0;
`endif

        ctrl_reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("reset.we", ctrl_writeEnable, 1'b0);
        checkOutput("reset.reg", ctrl_writeReg, 5'd0);
        checkOutput("reset.data", data_writeReg, 32'h0);
        checkOutput("reset.mask", pending_mask, 32'h0);
        checkOutput("reset.a_ready", a_ready, 1'b0);
        checkOutput("reset.b_ready", b_ready, 1'b0);
        tick();
        ctrl_reset = 1'b0;
        #1;
        checkOutput("post_reset.a_ready", a_ready, 1'b1);
        checkOutput("post_reset.b_ready", b_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, vecs[i].r, vecs[i].d, 0, 0, 0);
            checkOutput("vec.a_ready", a_ready, 1'b1);
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("vec.held_we", ctrl_writeEnable, 1'b0);
            checkOutput("vec.held_mask", pending_mask, vecs[i].mask);
            tick();
            checkOutput("vec.we", ctrl_writeEnable, vecs[i].we);
            if (vecs[i].we) begin
                checkOutput("vec.reg", ctrl_writeReg, vecs[i].r);
                checkOutput("vec.data", data_writeReg, vecs[i].d);
            end
            checkOutput("vec.commit_mask", pending_mask, vecs[i].mask);
            tick();
            checkOutput("vec.done_we", ctrl_writeEnable, 1'b0);
            checkOutput("vec.done_mask", pending_mask, 32'h0);
        end

        runBurst("burst1", 1'b0);
        runBurst("burst2", rrSecondB);

        applyStimulus(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("samereg.a_ready", a_ready, 1'b0);
        checkOutput("samereg.b_ready", b_ready, 1'b1);
        checkOutput("samereg.mask", pending_mask, 32'h200);
        tick();
        checkWrite("samereg.first", 5'd9, 32'h2, 32'h200);
        tick();
        checkWrite("samereg.second", 5'd9, 32'h1, 32'h200);
        tick();
        checkOutput("samereg.idle_we", ctrl_writeEnable, 1'b0);
        checkOutput("samereg.final_data", data_writeReg, 32'h1);

        checkOutput("r0.b_ready_pre", b_ready, 1'b1);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("r0.b_ready_held", b_ready, 1'b1);
        checkOutput("r0.mask_held", pending_mask, 32'h0);
        tick();
        checkOutput("r0.we", ctrl_writeEnable, 1'b0);
        checkOutput("r0.mask", pending_mask, 32'h0);
        checkOutput("r0.reg_hold", ctrl_writeReg, 5'd9);
        checkOutput("r0.data_hold", data_writeReg, 32'h1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 5'(i + 1), 32'((i + 1) * 16), 0, 0, 0);
            checkOutput("stream.a_ready", a_ready, 1'b1);
            tick();
            if (i >= 1)
                checkWrite("stream.write", 5'(i), 32'(i * 16),
                           (32'd1 << i) | (32'd1 << (i + 1)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("stream.last", 5'd8, 32'h80, 32'h100);
        tick();
        checkOutput("stream.idle_we", ctrl_writeEnable, 1'b0);

        applyStimulus(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midreset.mask_full", pending_mask, 32'h50);
        #1 ctrl_reset = 1'b1;
        #1;
        checkOutput("midreset.we", ctrl_writeEnable, 1'b0);
        checkOutput("midreset.reg", ctrl_writeReg, 5'd0);
        checkOutput("midreset.data", data_writeReg, 32'h0);
        checkOutput("midreset.mask", pending_mask, 32'h0);
        checkOutput("midreset.a_ready", a_ready, 1'b0);
        checkOutput("midreset.b_ready", b_ready, 1'b0);
        #1 ctrl_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("after_reset.we", ctrl_writeEnable, 1'b0);
            checkOutput("after_reset.mask", pending_mask, 32'h0);
            checkOutput("after_reset.a_ready", a_ready, 1'b1);
            checkOutput("after_reset.b_ready", b_ready, 1'b1);
        end

        runBurst("burst3", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
